// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: command word field layout and type/target codes shared by the GPU command path.
package gpu_cmd_pkg;
   localparam int TYPE_W = 2;
   localparam int MEM_W  = 2;
   // Fields are placed from the command MSB down: type at [CMD_W-1 -: TYPE_W], memory target just below.
   localparam int TYPE_OFS = 1;
   localparam int MEM_OFS  = 3;
   localparam logic [TYPE_W-1:0] CMD_RESET = 2'b00;
   localparam logic [TYPE_W-1:0] CMD_READ  = 2'b01;
   localparam logic [TYPE_W-1:0] CMD_WRITE = 2'b10;
   localparam logic [TYPE_W-1:0] CMD_RSVD  = 2'b11;
   localparam logic [MEM_W-1:0]  MEM_RAM   = 2'b00;
   localparam logic [MEM_W-1:0]  MEM_FLASH = 2'b01;
   localparam logic [MEM_W-1:0]  MEM_VRAM  = 2'b10;
   localparam logic [MEM_W-1:0]  MEM_REG   = 2'b11;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with independent occupancy counter; a full FIFO refuses pushes even on a pop edge.
module cmd_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          wr_en, rd_en;
   assign full_o  = level_q == LW'(DEPTH);
   assign empty_o = level_q == '0;
   assign wr_en   = push_i && !full_o;
   assign rd_en   = pop_i && !empty_o;
   assign level_d = level_q + LW'(wr_en) - LW'(rd_en);
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;
   always_ff @(posedge clk) if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/command_queue_ctrl.sv
// command_queue_ctrl: command FIFO in front of the GPU with registered issue and block-offset run tagging.
// Define CMD_FILTER_EN to pop reserved-type commands without issuing them.
module command_queue_ctrl
   import gpu_cmd_pkg::*;
#(
   parameter int CMD_W    = 16,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 8,
   parameter int OFFSET_W = 12
) (
   input  logic                   pipelineClk,
   input  logic                   rst,
   input  logic                   inValid,
   input  logic [CMD_W-1:0]       inCommand,
   input  logic [DATA_W-1:0]      inData,
   input  logic                   gpuBusy,
   output logic                   inReady,
   output logic                   gpuValid,
   output logic [CMD_W-1:0]       gpuCommand,
   output logic [DATA_W-1:0]      gpuData,
   output logic [OFFSET_W-1:0]    gpuOffset,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);
   logic [CMD_W+DATA_W-1:0] head;
   logic [CMD_W-1:0]        head_cmd;
   logic                    full, empty, pop, drop, issue, run;
   logic                    valid_q, last_vld_q, ovf_q;
   logic [CMD_W-1:0]        cmd_q;
   logic [DATA_W-1:0]       data_q;
   logic [OFFSET_W-1:0]     offset_q;
   cmd_fifo #(.W(CMD_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (pipelineClk),
      .rst     (rst),
      .push_i  (inValid),
      .pop_i   (!gpuBusy),
      .wdata_i ({inCommand, inData}),
      .rdata_o (head),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );
   assign head_cmd = head[CMD_W+DATA_W-1:DATA_W];
   assign pop      = !gpuBusy && !empty;
`ifdef CMD_FILTER_EN
   assign drop = head_cmd[CMD_W-1 -: TYPE_W] == CMD_RSVD;
`else
   assign drop = 1'b0;
`endif
   assign issue = pop && !drop;
   // gpuCommand only changes on issue, so it doubles as the last-issued command for run tracking.
   assign run   = last_vld_q && head_cmd == cmd_q;
   always_ff @(posedge pipelineClk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         last_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         cmd_q      <= '0;
         data_q     <= '0;
         offset_q   <= '0;
      end else begin
         valid_q <= issue;
         if (issue) begin
            cmd_q      <= head_cmd;
            data_q     <= head[DATA_W-1:0];
            offset_q   <= run ? offset_q + OFFSET_W'(1) : '0;
            last_vld_q <= 1'b1;
         end
         if (inValid && full) ovf_q <= 1'b1;
      end
   end
   assign inReady    = !full;
   assign gpuValid   = valid_q;
   assign gpuCommand = cmd_q;
   assign gpuData    = data_q;
   assign gpuOffset  = offset_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_command_queue_ctrl.sv
// tb_command_queue_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_command_queue_ctrl;
   localparam int CMD_W = 16, DATA_W = 16, DEPTH = 8, OFFSET_W = 12;
   logic pipelineClk = 0, rst = 1, inValid = 0, gpuBusy = 0;
   logic [CMD_W-1:0] inCommand = '0;
   logic [DATA_W-1:0] inData = '0;
   logic inReady, gpuValid, overflow;
   logic [CMD_W-1:0] gpuCommand;
   logic [DATA_W-1:0] gpuData;
   logic [OFFSET_W-1:0] gpuOffset;
   logic [$clog2(DEPTH):0] level;
   int errors = 0, checks = 0;
   logic [31:0] mq[$];
   bit mv, mlv, movf;
   logic [15:0] mcmd, mdata;
   int moff;
   int seen_off[$];
   logic [15:0] seen_cmd[$];

   command_queue_ctrl #(.CMD_W(CMD_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .OFFSET_W(OFFSET_W)) dut (
      .pipelineClk(pipelineClk), .rst(rst), .inValid(inValid), .inCommand(inCommand), .inData(inData),
      .gpuBusy(gpuBusy), .inReady(inReady), .gpuValid(gpuValid), .gpuCommand(gpuCommand),
      .gpuData(gpuData), .gpuOffset(gpuOffset), .level(level), .overflow(overflow)
   );

   always #5 pipelineClk = ~pipelineClk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit filtered(input logic [31:0] e);
`ifdef CMD_FILTER_EN
      return e[31:30] == 2'b11;
`else
      return 1'b0;
`endif
   endfunction

   initial forever begin
      @(posedge pipelineClk or posedge rst);
      if (rst) begin
         mq.delete(); mv = 0; mlv = 0; movf = 0; mcmd = 0; mdata = 0; moff = 0;
      end else begin
         bit was_full;
         logic [31:0] e;
         was_full = mq.size() == DEPTH;
         mv = 0;
         if (!gpuBusy && mq.size() > 0) begin
            e = mq.pop_front();
            if (!filtered(e)) begin
               moff = (mlv && e[31:16] == mcmd) ? (moff + 1) % (1 << OFFSET_W) : 0;
               mcmd = e[31:16]; mdata = e[15:0]; mlv = 1; mv = 1;
            end
         end
         if (inValid) begin
            if (was_full) movf = 1;
            else mq.push_back({inCommand, inData});
         end
      end
   end

   always @(negedge pipelineClk) if (!rst) begin
      check("gpuValid", gpuValid, mv);
      check("gpuCommand", gpuCommand, mcmd);
      check("gpuData", gpuData, mdata);
      check("gpuOffset", gpuOffset, moff);
      check("level", level, mq.size());
      check("inReady", inReady, mq.size() < DEPTH);
      check("overflow", overflow, movf);
      if (gpuValid) begin
         seen_off.push_back(int'(gpuOffset));
         seen_cmd.push_back(gpuCommand);
      end
   end

   task automatic cyc();
      @(negedge pipelineClk);
   endtask

   task automatic push(input logic [15:0] c, input logic [15:0] d);
      inValid = 1; inCommand = c; inData = d;
      cyc();
      inValid = 0;
   endtask

   initial begin
      repeat (2) cyc();
      check("rst_level", level, 0);
      check("rst_inReady", inReady, 1);
      check("rst_gpuValid", gpuValid, 0);
      check("rst_overflow", overflow, 0);
      rst = 0;
      // single entry latency
      push(16'h8800, 16'h1234);
      check("t1_level_after_push", level, 1);
      check("t1_valid_early", gpuValid, 0);
      cyc();
      check("t1_valid", gpuValid, 1);
      check("t1_cmd", gpuCommand, 16'h8800);
      check("t1_data", gpuData, 16'h1234);
      check("t1_off", gpuOffset, 0);
      check("t1_level", level, 0);
      cyc();
      check("t1_pulse_end", gpuValid, 0);
      check("t1_hold_cmd", gpuCommand, 16'h8800);
      // fill and overflow
      gpuBusy = 1;
      for (int i = 0; i < 9; i++) begin
         push(16'h8100 + 16'(i), 16'hA000 + 16'(i));
         if (i == 6) check("t2_ready_at7", inReady, 1);
         if (i == 7) check("t2_ready_full", inReady, 0);
      end
      check("t2_overflow", overflow, 1);
      check("t2_level", level, 8);
      gpuBusy = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         check("t2_drain_valid", gpuValid, 1);
         check("t2_drain_cmd", gpuCommand, 16'h8100 + 16'(k));
      end
      cyc();
      check("t2_drain_done", gpuValid, 0);
      check("t2_overflow_sticky", overflow, 1);
      // run offsets
      seen_off.delete(); seen_cmd.delete();
      for (int i = 0; i < 5; i++) push(16'h9000, 16'(i));
      push(16'h5000, 16'h0005);
      repeat (3) cyc();
      check("t3_count", seen_off.size(), 6);
      for (int i = 0; i < 6; i++) check("t3_off", seen_off[i], (i < 5) ? i : 0);
      // offset wrap at 2^OFFSET_W
      seen_off.delete(); seen_cmd.delete();
      for (int i = 0; i < 4098; i++) push(16'h9400, 16'(i));
      repeat (3) cyc();
      check("t4_count", seen_off.size(), 4098);
      check("t4_off_max", seen_off[4095], 4095);
      check("t4_off_wrap0", seen_off[4096], 0);
      check("t4_off_wrap1", seen_off[4097], 1);
      // reserved filtering
      seen_off.delete(); seen_cmd.delete();
      push(16'h4000, 16'h0001);
      push(16'hC000, 16'h0002);
      push(16'h4000, 16'h0003);
      repeat (3) cyc();
`ifdef CMD_FILTER_EN
      check("t5_count", seen_off.size(), 2);
      check("t5_off0", seen_off[0], 0);
      check("t5_off1", seen_off[1], 1);
      check("t5_cmd1", seen_cmd[1], 16'h4000);
`else
      check("t5_count", seen_off.size(), 3);
      check("t5_off0", seen_off[0], 0);
      check("t5_off1", seen_off[1], 0);
      check("t5_off2", seen_off[2], 0);
      check("t5_cmd1", seen_cmd[1], 16'hC000);
`endif
      check("t5_level", level, 0);
      // asynchronous reset mid-operation
      gpuBusy = 1;
      for (int i = 0; i < 5; i++) push(16'h8200 + 16'(i), 16'(i));
      gpuBusy = 0;
      cyc();
      gpuBusy = 1;
      check("t6_valid_before", gpuValid, 1);
      check("t6_level_before", level, 4);
      #2 rst = 1;
      #1;
      check("t6_valid_async", gpuValid, 0);
      check("t6_level_async", level, 0);
      check("t6_ready_async", inReady, 1);
      check("t6_overflow_async", overflow, 0);
      repeat (2) cyc();
      rst = 0;
      gpuBusy = 0;
      seen_off.delete(); seen_cmd.delete();
      repeat (6) cyc();
      check("t6_no_issue", seen_off.size(), 0);
      check("t6_level_after", level, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
